// File: rtl/scpad_dram_write_issuer.sv
// scpad_dram_write_issuer
// Takes scratchpad->DRAM row writes from the head of the write request queue and
// issues them on the DRAM write channel. It builds each byte strobe from num_bytes,
// tracks in-flight writes per transaction ID, and turns each DRAM response into a
// one-cycle completion pulse.
// Optional feature macro: SCPAD_WR_ALIGN_CHECK_EN. When it is defined, a
// row-misaligned request is accepted but not issued, and it completes with an error.
module scpad_dram_write_issuer #(
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int DATA_BYTES      = 64,
  parameter int COL_IDX_WIDTH   = 7,
  parameter int DRAM_ID_WIDTH   = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  input  logic [DRAM_ADDR_WIDTH-1:0]             req_addr,
  input  logic [COL_IDX_WIDTH-1:0]               req_num_bytes,
  input  logic [DATA_BYTES*8-1:0]                req_wdata,
  input  logic [DRAM_ID_WIDTH-1:0]               req_id,
  output logic                                   req_accepted,
  output logic                                   dram_wr_valid,
  input  logic                                   dram_wr_ready,
  output logic [DRAM_ADDR_WIDTH-1:0]             dram_wr_addr,
  output logic [DATA_BYTES*8-1:0]                dram_wr_data,
  output logic [DATA_BYTES-1:0]                  dram_wr_strb,
  output logic [DRAM_ID_WIDTH-1:0]               dram_wr_id,
  input  logic                                   dram_resp_valid,
  input  logic [DRAM_ID_WIDTH-1:0]               dram_resp_id,
  output logic                                   wr_complete,
  output logic [DRAM_ID_WIDTH-1:0]               wr_complete_id,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt,
  output logic                                   err_sticky
);

  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int NUM_IDS = 1 << DRAM_ID_WIDTH;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
`ifdef SCPAD_WR_ALIGN_CHECK_EN
  localparam int OFS_W = $clog2(DATA_BYTES);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [DRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_BYTES*8-1:0]      data_q, data_d;
  logic [DATA_BYTES-1:0]        strb_q, strb_d;
  logic [DRAM_ID_WIDTH-1:0]     id_q, id_d;
  logic [NUM_IDS-1:0]           busy_q, busy_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         cmpl_q, cmpl_d;
  logic [DRAM_ID_WIDTH-1:0]     cmpl_id_q, cmpl_id_d;

  logic                         accept;
  logic                         misaligned;
  logic                         oversize;
  logic                         resp_hit;
  logic                         resp_err;
  logic                         issue_done;
  int                           n_bytes;
  logic [DATA_BYTES-1:0]        strb_new;

  // Decide what happens this cycle: accept the head, retire the issue, match the response, build the strobe
  always_comb begin
    misaligned = 1'b0;
`ifdef SCPAD_WR_ALIGN_CHECK_EN
    misaligned = (req_addr[OFS_W-1:0] != '0);
`endif
    resp_hit   = dram_resp_valid && busy_q[dram_resp_id];
    resp_err   = dram_resp_valid && !busy_q[dram_resp_id];
    issue_done = (state_q == ISSUE) && dram_wr_ready;
    // A misaligned request completes through the same pulse a response uses, so defer it one cycle on a clash
    accept     = !rst && (state_q == IDLE) && req_valid && (cnt_q < MAX_CNT) &&
                 !busy_q[req_id] && !(misaligned && resp_hit);
    oversize   = int'(req_num_bytes) > DATA_BYTES;
    if (req_num_bytes == '0) begin
      n_bytes = DATA_BYTES;
    end else if (oversize) begin
      n_bytes = DATA_BYTES;
    end else begin
      n_bytes = int'(req_num_bytes);
    end
    strb_new = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      strb_new[i] = (i < n_bytes);
    end
  end

  // Compute the next value of every register from this cycle's events
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    id_d      = id_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cmpl_d    = 1'b0;
    cmpl_id_d = '0;

    if (resp_err) begin
      err_d = 1'b1;
    end
    if (resp_hit) begin
      busy_d[dram_resp_id] = 1'b0;
      cmpl_d               = 1'b1;
      cmpl_id_d            = dram_resp_id;
    end
    if (issue_done) begin
      busy_d[id_q] = 1'b1;
      state_d      = IDLE;
    end
    if (issue_done && !resp_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue_done && resp_hit) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (accept) begin
      if (oversize) begin
        err_d = 1'b1;
      end
      if (misaligned) begin
        cmpl_d    = 1'b1;
        cmpl_id_d = req_id;
        err_d     = 1'b1;
      end else begin
        state_d = ISSUE;
        addr_d  = req_addr;
        data_d  = req_wdata;
        strb_d  = strb_new;
        id_d    = req_id;
      end
    end
  end

  // State, payload and tracking registers; reset drops any write that is being issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      id_q      <= '0;
      busy_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cmpl_q    <= 1'b0;
      cmpl_id_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cmpl_q    <= cmpl_d;
      cmpl_id_q <= cmpl_id_d;
    end
  end

  assign req_accepted    = accept;
  assign dram_wr_valid   = (state_q == ISSUE);
  assign dram_wr_addr    = addr_q;
  assign dram_wr_data    = data_q;
  assign dram_wr_strb    = strb_q;
  assign dram_wr_id      = id_q;
  assign wr_complete     = cmpl_q;
  assign wr_complete_id  = cmpl_id_q;
  assign outstanding_cnt = cnt_q;
  assign err_sticky      = err_q;

endmodule

// File: tb/tb_scpad_dram_write_issuer.sv
// Testbench for scpad_dram_write_issuer: directed scenarios plus randomized traffic
// checked each cycle against a transaction-level reference model.
module tb_scpad_dram_write_issuer;

  localparam int AW = 32;
  localparam int DB = 64;
  localparam int CW = 7;
  localparam int IW = 4;
  localparam int MO = 8;
  localparam int NW = $clog2(MO + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [AW-1:0]     req_addr;
  logic [CW-1:0]     req_num_bytes;
  logic [DB*8-1:0]   req_wdata;
  logic [IW-1:0]     req_id;
  logic              req_accepted;
  logic              dram_wr_valid;
  logic              dram_wr_ready;
  logic [AW-1:0]     dram_wr_addr;
  logic [DB*8-1:0]   dram_wr_data;
  logic [DB-1:0]     dram_wr_strb;
  logic [IW-1:0]     dram_wr_id;
  logic              dram_resp_valid;
  logic [IW-1:0]     dram_resp_id;
  logic              wr_complete;
  logic [IW-1:0]     wr_complete_id;
  logic [NW-1:0]     outstanding_cnt;
  logic              err_sticky;

  always #5 clk = ~clk;

  scpad_dram_write_issuer #(
    .DRAM_ADDR_WIDTH(AW), .DATA_BYTES(DB), .COL_IDX_WIDTH(CW),
    .DRAM_ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_num_bytes(req_num_bytes),
    .req_wdata(req_wdata), .req_id(req_id), .req_accepted(req_accepted),
    .dram_wr_valid(dram_wr_valid), .dram_wr_ready(dram_wr_ready),
    .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data),
    .dram_wr_strb(dram_wr_strb), .dram_wr_id(dram_wr_id),
    .dram_resp_valid(dram_resp_valid), .dram_resp_id(dram_resp_id),
    .wr_complete(wr_complete), .wr_complete_id(wr_complete_id),
    .outstanding_cnt(outstanding_cnt), .err_sticky(err_sticky)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one held write being issued, a set of in-flight IDs, a pending completion
  bit              m_issuing;
  logic [AW-1:0]   m_addr;
  logic [DB*8-1:0] m_data;
  logic [DB-1:0]   m_strb;
  logic [IW-1:0]   m_id;
  bit [2**IW-1:0]  m_busy;
  bit              m_err;
  bit              m_cmpl;
  logic [IW-1:0]   m_cmpl_id;
  bit              m_acc;

  task automatic checkOutput(input string tag, input logic [DB*8-1:0] got, input logic [DB*8-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DB-1:0] expStrb(input int nb);
    logic [DB-1:0] ones;
    int n;
    ones = '1;
    n = (nb == 0) ? DB : ((nb > DB) ? DB : nb);
    return ones >> (DB - n);
  endfunction

  function automatic logic [DB*8-1:0] randData();
    logic [DB*8-1:0] d;
    for (int k = 0; k < DB * 8 / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic modelReset();
    m_issuing = 0; m_addr = '0; m_data = '0; m_strb = '0; m_id = '0;
    m_busy = '0; m_err = 0; m_cmpl = 0; m_cmpl_id = '0; m_acc = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model at the rising edge
  task automatic applyStimulus(input bit rv, input logic [AW-1:0] a, input int nb,
                               input logic [DB*8-1:0] d, input logic [IW-1:0] id,
                               input bit rdy, input bit respv, input logic [IW-1:0] rid);
    int cnt;
    bit misal;
    bit hit;
    bit [2**IW-1:0] nbusy;
    req_valid = rv; req_addr = a; req_num_bytes = CW'(nb); req_wdata = d; req_id = id;
    dram_wr_ready = rdy; dram_resp_valid = respv; dram_resp_id = rid;
    @(negedge clk);
    cnt = $countones(m_busy);
    misal = 0;
`ifdef SCPAD_WR_ALIGN_CHECK_EN
    misal = (a % DB) != 0;
`endif
    hit = respv && m_busy[rid];
    m_acc = !m_issuing && rv && (cnt < MO) && !m_busy[id] && !(misal && hit);
    checkOutput("req_accepted", req_accepted, m_acc);
    checkOutput("wr_valid", dram_wr_valid, m_issuing);
    if (m_issuing) begin
      checkOutput("wr_addr", dram_wr_addr, m_addr);
      checkOutput("wr_data", dram_wr_data, m_data);
      checkOutput("wr_strb", dram_wr_strb, m_strb);
      checkOutput("wr_id", dram_wr_id, m_id);
    end
    checkOutput("wr_complete", wr_complete, m_cmpl);
    if (m_cmpl) checkOutput("complete_id", wr_complete_id, m_cmpl_id);
    checkOutput("outstanding", outstanding_cnt, cnt);
    checkOutput("err_sticky", err_sticky, m_err);
    @(posedge clk);
    nbusy = m_busy;
    m_cmpl = 0; m_cmpl_id = '0;
    if (respv && !m_busy[rid]) m_err = 1;
    if (hit) begin
      nbusy[rid] = 0; m_cmpl = 1; m_cmpl_id = rid;
    end
    if (m_issuing && rdy) begin
      nbusy[m_id] = 1; m_issuing = 0;
    end
    if (m_acc) begin
      if (nb > DB) m_err = 1;
      if (misal) begin
        m_cmpl = 1; m_cmpl_id = id; m_err = 1;
      end else begin
        m_issuing = 1; m_addr = a; m_data = d; m_id = id; m_strb = expStrb(nb);
      end
    end
    m_busy = nbusy;
    #1;
  endtask

  task automatic resetDut();
    rst = 1;
    req_valid = 0; req_addr = '0; req_num_bytes = '0; req_wdata = '0; req_id = '0;
    dram_wr_ready = 0; dram_resp_valid = 0; dram_resp_id = '0;
    #2;
    checkOutput("rst_accepted", req_accepted, 0);
    checkOutput("rst_wr_valid", dram_wr_valid, 0);
    checkOutput("rst_wr_addr", dram_wr_addr, 0);
    checkOutput("rst_wr_data", dram_wr_data, 0);
    checkOutput("rst_wr_strb", dram_wr_strb, 0);
    checkOutput("rst_wr_id", dram_wr_id, 0);
    checkOutput("rst_complete", wr_complete, 0);
    checkOutput("rst_count", outstanding_cnt, 0);
    checkOutput("rst_err", err_sticky, 0);
    @(negedge clk);
    rst = 0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  // Accept, issue with ready on the first ISSUE cycle, respond, then observe the completion
  task automatic oneWrite(input logic [AW-1:0] a, input int nb, input logic [IW-1:0] id,
                          input logic [DB-1:0] exp_strb);
    applyStimulus(1, a, nb, randData(), id, 0, 0, 0);
    checkOutput("strb_direct", dram_wr_strb, exp_strb);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, id);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic drainAll();
    for (int i = 0; i < 2**IW; i++) begin
      if (m_busy[i]) applyStimulus(0, 0, 0, '0, 0, 0, 1, IW'(i));
    end
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic randomPhase(input int cycles, input bit allow_bad);
    bit hv;
    logic [AW-1:0] ha;
    int hnb;
    logic [DB*8-1:0] hd;
    logic [IW-1:0] hid;
    bit rdy, respv;
    logic [IW-1:0] rid;
    logic [IW-1:0] q[$];
    hv = 0; ha = '0; hnb = 0; hd = '0; hid = '0;
    for (int c = 0; c < cycles; c++) begin
      if (!hv && $urandom_range(0, 3) != 0) begin
        hv = 1;
        ha = $urandom;
        if ($urandom_range(0, 3) != 0) ha[5:0] = '0;
        case ($urandom_range(0, 4))
          0: hnb = 0;
          1: hnb = DB;
          2: hnb = allow_bad ? $urandom_range(DB + 1, 127) : 1;
          default: hnb = $urandom_range(1, DB - 1);
        endcase
        hd = randData();
        hid = IW'($urandom_range(0, 11));
      end
      rdy = ($urandom_range(0, 2) != 0);
      respv = 0; rid = '0;
      q.delete();
      for (int i = 0; i < 2**IW; i++) if (m_busy[i]) q.push_back(IW'(i));
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        respv = 1; rid = q[$urandom_range(0, q.size() - 1)];
      end else if (allow_bad && $urandom_range(0, 40) == 0) begin
        respv = 1; rid = IW'($urandom);
      end
      applyStimulus(hv, ha, hnb, hd, hid, rdy, respv, rid);
      if (m_acc) hv = 0;
    end
    drainAll();
  endtask

  initial begin
    logic [DB*8-1:0] d;
    logic [DB-1:0] all_ones;
    all_ones = '1;
    modelReset();
    resetDut();

    // Single full-row write, then strobe boundaries
    oneWrite(32'h1000, 0, 3, all_ones);
    oneWrite(32'h2000, 5, 1, 64'h1F);
    oneWrite(32'h3000, 64, 2, all_ones);
    checkOutput("err_before_oversize", err_sticky, 0);
    oneWrite(32'h4000, 100, 4, all_ones);
    checkOutput("err_after_oversize", err_sticky, 1);

    // Fill to the outstanding limit, then a ninth request must wait for a response
    resetDut();
    for (int i = 0; i < MO; i++) begin
      applyStimulus(1, AW'(i * 64), 0, randData(), IW'(i), 0, 0, 0);
      applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    end
    d = randData();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h8000, 0, d, 8, 0, 0, 0);
    end
    checkOutput("full_count", outstanding_cnt, MO);
    applyStimulus(1, 32'h8000, 0, d, 8, 0, 1, 2);
    applyStimulus(1, 32'h8000, 0, d, 8, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    drainAll();

    // Same ID stalls until its own response arrives
    applyStimulus(1, 32'h5000, 8, randData(), 5, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    d = randData();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h5040, 16, d, 5, 0, 0, 0);
    checkOutput("id5_count", outstanding_cnt, 1);
    applyStimulus(1, 32'h5040, 16, d, 5, 0, 1, 5);
    applyStimulus(1, 32'h5040, 16, d, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    drainAll();

    // Back-pressure for ten cycles, with a response to an unissued ID in the middle
    applyStimulus(1, 32'h6000, 33, randData(), 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, '0, 0, 0, (i == 4), 9);
    checkOutput("err_bad_resp", err_sticky, 1);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    drainAll();

    // Randomized traffic: legal only, then with protocol errors
    resetDut();
    randomPhase(2500, 0);
    checkOutput("err_legal_traffic", err_sticky, 0);
    randomPhase(2500, 1);

    // Reset while a write is being issued, with another already outstanding
    applyStimulus(1, 32'h7000, 0, randData(), 6, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 0);
    applyStimulus(1, 32'h7040, 0, randData(), 4, 0, 0, 0);
    checkOutput("pre_rst_valid", dram_wr_valid, 1);
    resetDut();
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);

`ifdef SCPAD_WR_ALIGN_CHECK_EN
    applyStimulus(1, 32'h1004, 0, randData(), 2, 0, 0, 0);
    checkOutput("align_no_valid", dram_wr_valid, 0);
    checkOutput("align_complete", wr_complete, 1);
    checkOutput("align_complete_id", wr_complete_id, 2);
    checkOutput("align_err", err_sticky, 1);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
